// File: rtl/ndn_pkt_pkg.sv
// Shared NDN packet constants and TX scheduler state encoding.
// Imported by the scheduler top and its testbench.
package ndn_pkt_pkg;

   localparam int PREFIX_BYTES = 8;
   localparam int DATA_BYTES   = 32;
   localparam int PKT_TYPE_BIT = 6;
   localparam logic PKT_INTEREST = 1'b1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_META,
      S_PREFIX,
      S_DATA,
      S_GUARD
   } sched_state_t;

endpackage

// File: rtl/spi_tx_scheduler_if.sv
// Requester byte streams in, SPI TX start/byte out.
// master = scheduler side, slave = sources + SPI side.
interface spi_tx_scheduler_if #(
   parameter int NUM_REQ = 4
);

   logic [NUM_REQ-1:0]   req_valid;
   logic [8*NUM_REQ-1:0] req_byte;
   logic [NUM_REQ-1:0]   req_ready;
   logic                 tx_valid;
   logic [7:0]           tx_byte;
   logic [2:0]           grant_id;
   logic                 busy;
   logic                 err_underrun;

   modport master (
      input  req_valid,
      input  req_byte,
      output req_ready,
      output tx_valid,
      output tx_byte,
      output grant_id,
      output busy,
      output err_underrun
   );

   modport slave (
      output req_valid,
      output req_byte,
      input  req_ready,
      input  tx_valid,
      input  tx_byte,
      input  grant_id,
      input  busy,
      input  err_underrun
   );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin pick of the first request at or after the pointer.
// Pointer moves past the winner only when the grant is taken.
module rr_arbiter #(
   parameter int NUM_REQ = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] req,
   input  logic               en,
   output logic               gnt_any,
   output logic [2:0]         gnt_id
);

   logic [2:0] ptr;
   int         idx;

   // Scan from the farthest offset down so the nearest one wins last.
   always_comb begin
      gnt_any = 1'b0;
      gnt_id  = '0;
      idx     = 0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         idx = int'(ptr) + i;
         if (idx >= NUM_REQ)
            idx = idx - NUM_REQ;
         if (req[idx]) begin
            gnt_any = 1'b1;
            gnt_id  = 3'(idx);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr <= '0;
      end else if (en && gnt_any) begin
         if (gnt_id == 3'(NUM_REQ - 1))
            ptr <= '0;
         else
            ptr <= gnt_id + 3'd1;
      end
   end

endmodule

// File: rtl/spi_tx_scheduler.sv
// Shares one SPI TX path among NUM_REQ packet sources.
// Fixed 41-byte gap-free burst per grant, then a serialization guard.
module spi_tx_scheduler #(
   parameter int NUM_REQ      = 4,
   parameter int PREFIX_BYTES = ndn_pkt_pkg::PREFIX_BYTES,
   parameter int DATA_BYTES   = ndn_pkt_pkg::DATA_BYTES,
   parameter int GUARD_CYCLES = 332
) (
   input logic                clk,
   input logic                rst,
   spi_tx_scheduler_if.master bus
);

   import ndn_pkt_pkg::*;

   localparam int BW = $clog2(DATA_BYTES + 1);
   localparam int GW = $clog2(GUARD_CYCLES);

   sched_state_t state;
   logic [BW-1:0] byte_cnt;
   logic [GW-1:0] guard_cnt;
   logic [2:0]    grant_q;
   logic          is_interest;
   logic          tx_valid_q;
   logic          busy_q;

   logic               gnt_any;
   logic [2:0]         gnt_id;
   logic               need_src;
   logic               src_valid;
   logic [7:0]         src_byte;
   logic [NUM_REQ-1:0] sel;
   logic [7:0]         tx_byte_c;
   logic [NUM_REQ-1:0] ready_c;
   logic               err_c;

   rr_arbiter #(
      .NUM_REQ(NUM_REQ)
   ) u_arb (
      .clk    (clk),
      .rst    (rst),
      .req    (bus.req_valid),
      .en     (state == S_IDLE),
      .gnt_any(gnt_any),
      .gnt_id (gnt_id)
   );

   always_comb begin
      src_valid = 1'b0;
      src_byte  = 8'h00;
      sel       = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_q == 3'(i)) begin
            src_valid = bus.req_valid[i];
            src_byte  = bus.req_byte[8*i +: 8];
            sel[i]    = 1'b1;
         end
      end
   end

   // Interest packets end after the prefix; DATA is zero padding.
   assign need_src = (state == S_META) || (state == S_PREFIX) ||
                     ((state == S_DATA) && !is_interest);

   always_comb begin
      tx_byte_c = 8'h00;
      ready_c   = '0;
      err_c     = 1'b0;
      if (need_src) begin
         if (src_valid) begin
            tx_byte_c = src_byte;
            ready_c   = sel;
         end else begin
            err_c = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= S_IDLE;
         byte_cnt    <= '0;
         guard_cnt   <= '0;
         grant_q     <= '0;
         is_interest <= 1'b0;
         tx_valid_q  <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         tx_valid_q <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (gnt_any) begin
                  grant_q    <= gnt_id;
                  tx_valid_q <= 1'b1;
                  busy_q     <= 1'b1;
                  state      <= S_START;
               end
            end
            S_START: state <= S_META;
            S_META: begin
               is_interest <= (tx_byte_c[PKT_TYPE_BIT] == PKT_INTEREST);
               byte_cnt    <= BW'(PREFIX_BYTES - 1);
               state       <= S_PREFIX;
            end
            S_PREFIX: begin
               if (byte_cnt == '0) begin
                  byte_cnt <= BW'(DATA_BYTES - 1);
                  state    <= S_DATA;
               end else begin
                  byte_cnt <= byte_cnt - BW'(1);
               end
            end
            S_DATA: begin
               if (byte_cnt == '0) begin
                  guard_cnt <= GW'(GUARD_CYCLES - 1);
                  state     <= S_GUARD;
               end else begin
                  byte_cnt <= byte_cnt - BW'(1);
               end
            end
            S_GUARD: begin
               if (guard_cnt == '0) begin
                  busy_q <= 1'b0;
                  state  <= S_IDLE;
               end else begin
                  guard_cnt <= guard_cnt - GW'(1);
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.tx_valid     = tx_valid_q;
   assign bus.tx_byte      = tx_byte_c;
   assign bus.req_ready    = ready_c;
   assign bus.grant_id     = grant_q;
   assign bus.busy         = busy_q;
   assign bus.err_underrun = err_c;

endmodule
